tdpram_bwe_clr: RTL and testbench

// - True dual-port synchronous RAM for BPU tables (BHT/BTB/PHT) with per-byte write enables.
// - Adds a selectable read-during-write mode, an optional output pipeline stage and a

---
 rtl/tdpram_bwe_clr_pkg.sv | 18 +
 rtl/tdpram_clr_ctrl.sv | 57 +++++
 rtl/tdpram_bwe_clr.sv | 145 ++++++++++++++
 tb/tb_tdpram_bwe_clr.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdpram_bwe_clr_pkg.sv
// Shared types and helpers for the BPU table RAM and its clear sequencer.
package tdpram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

    function automatic int nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/tdpram_clr_ctrl.sv
// Clear sequencer: walks the table two entries per cycle (one per RAM port) and
// holds ready low until every entry has been written with the clear value.
module tdpram_clr_ctrl
    import tdpram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] clr_addr_a,
    output logic [ADDR_WIDTH-1:0] clr_addr_b,
    output logic                  clr_wr,
    output clr_state_e            state
);

    // Even address of the final pair (DEPTH-2); cnt only ever holds even values.
    localparam logic [ADDR_WIDTH-1:0] LAST = ~ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_ON_RESET ? CLR_RUN : CLR_IDLE;
            ready <= !CLR_ON_RESET;
            cnt   <= '0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state <= CLR_RUN;
                        ready <= 1'b0;
                        cnt   <= '0;
                    end
                end
                CLR_RUN: begin
                    cnt <= cnt + ADDR_WIDTH'(2);
                    if (cnt == LAST) begin
                        state <= CLR_IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= CLR_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign clr_addr_a = cnt;
    assign clr_addr_b = cnt | ADDR_WIDTH'(1);
    assign clr_wr     = (state == CLR_RUN);

endmodule

// File: rtl/tdpram_bwe_clr.sv
// True dual-port byte-write RAM for BPU tables with selectable read-during-write
// behaviour, optional output register and a built-in full-table clear.
module tdpram_bwe_clr
    import tdpram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 6,
    parameter int                    OUT_REG      = 0,
    parameter int                    RDW_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE    = '0,
    parameter bit                    CLR_ON_RESET = 1'b1,
    localparam int                   NB           = nb(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  ready,
    input  logic                  ena,
    input  logic [NB-1:0]         wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  rvalida,
    input  logic                  enb,
    input  logic [NB-1:0]         web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  rvalidb
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("tdpram_bwe_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [ADDR_WIDTH-1:0] clr_addr_a;
    logic [ADDR_WIDTH-1:0] clr_addr_b;
    logic                  clr_wr;
    clr_state_e            clr_state;

    tdpram_clr_ctrl #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .ready      (ready),
        .clr_addr_a (clr_addr_a),
        .clr_addr_b (clr_addr_b),
        .clr_wr     (clr_wr),
        .state      (clr_state)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic          acc_a, acc_b;
    logic [NB-1:0] wr_a, wr_b;
    logic          same_addr;

    // ready is low for the whole clear, which also blocks user traffic.
    assign acc_a     = ena & ready & (clr_state == CLR_IDLE);
    assign acc_b     = enb & ready & (clr_state == CLR_IDLE);
    assign wr_a      = acc_a ? wea : '0;
    assign wr_b      = acc_b ? web : '0;
    assign same_addr = (addra == addrb);

    // Port A is written after port B so it owns any lane both ports hit.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_addr_a] <= CLR_VALUE;
            mem[clr_addr_b] <= CLR_VALUE;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b[i]) mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr_a[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    always_comb begin
        rd_a = mem[addra];
        rd_b = mem[addrb];
        if (RDW_MODE == int'(RDW_WRITE_FIRST)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b[i] && same_addr) rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr_a[i])              rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr_a[i] && same_addr) rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                else if (wr_b[i])         rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic [DATA_WIDTH-1:0] dout1_a, dout1_b;
    logic                  rv1_a, rv1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout1_a <= '0;
            dout1_b <= '0;
            rv1_a   <= 1'b0;
            rv1_b   <= 1'b0;
        end else begin
            dout1_a <= acc_a ? rd_a : '0;
            dout1_b <= acc_b ? rd_b : '0;
            rv1_a   <= acc_a;
            rv1_b   <= acc_b;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] dout2_a, dout2_b;
        logic                  rv2_a, rv2_b;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout2_a <= '0;
                dout2_b <= '0;
                rv2_a   <= 1'b0;
                rv2_b   <= 1'b0;
            end else begin
                dout2_a <= dout1_a;
                dout2_b <= dout1_b;
                rv2_a   <= rv1_a;
                rv2_b   <= rv1_b;
            end
        end

        assign douta   = dout2_a;
        assign doutb   = dout2_b;
        assign rvalida = rv2_a;
        assign rvalidb = rv2_b;
    end else begin : g_no_out_reg
        assign douta   = dout1_a;
        assign doutb   = dout1_b;
        assign rvalida = rv1_a;
        assign rvalidb = rv1_b;
    end

endmodule

// File: tb/tb_tdpram_bwe_clr.sv
// Bench for tdpram_bwe_clr: dut0 is read-first with latency 1, dut1 is write-first
// with latency 2; both share every input so their tables hold identical contents.
module tb_tdpram_bwe_clr;

    localparam logic [31:0] CLRV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr_req = 1'b0;
    logic        ena = 1'b0, enb = 1'b0;
    logic [3:0]  wea = '0, web = '0;
    logic [3:0]  addra = '0, addrb = '0;
    logic [31:0] dina = '0, dinb = '0;

    logic        ready0, ready1;
    logic [31:0] douta0, doutb0, douta1, doutb1;
    logic        rvalida0, rvalidb0, rvalida1, rvalidb1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdpram_bwe_clr #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(0),
        .RDW_MODE(0), .CLR_VALUE(CLRV), .CLR_ON_RESET(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready0),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .rvalida(rvalida0),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .rvalidb(rvalidb0)
    );

    tdpram_bwe_clr #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(1),
        .RDW_MODE(1), .CLR_VALUE(CLRV), .CLR_ON_RESET(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready1),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .rvalida(rvalida1),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .rvalidb(rvalidb1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0; clr_req = 1'b0;
    endtask

    // Single read on one port; returns dut0 result (1 edge) and dut1 result (2 edges).
    task automatic do_read(input bit port_b, input logic [3:0] a,
                           output logic [31:0] d0, output logic v0, output logic v1_early,
                           output logic [31:0] d1, output logic v1);
        @(negedge clk);
        if (port_b) begin enb = 1'b1; web = '0; addrb = a; end
        else begin ena = 1'b1; wea = '0; addra = a; end
        @(negedge clk);
        idle_inputs();
        d0 = port_b ? doutb0 : douta0;
        v0 = port_b ? rvalidb0 : rvalida0;
        v1_early = port_b ? rvalidb1 : rvalida1;
        @(negedge clk);
        d1 = port_b ? doutb1 : douta1;
        v1 = port_b ? rvalidb1 : rvalida1;
    endtask

    task automatic do_write(input logic a_en, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                            input logic b_en, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
        @(negedge clk);
        ena = a_en; wea = wa; addra = aa; dina = da;
        enb = b_en; web = wb; addrb = ab; dinb = db;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_clear_done(input string tag);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) begin ena = 1'b0; wea = '0; end
            checks++;
            if (ready0 !== (k == 8) || ready1 !== (k == 8)) begin
                failures++;
                $display("FAIL %s_ready edge %0d: got %b/%b expected %b", tag, k, ready0, ready1, (k == 8));
            end
            checks++;
            if (douta0 !== 32'h0 || rvalida0 !== 1'b0 || douta1 !== 32'h0 || rvalida1 !== 1'b0) begin
                failures++;
                $display("FAIL %s_dout_zero edge %0d: got %h/%b %h/%b expected 0", tag, k,
                         douta0, rvalida0, douta1, rvalida1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b/%b expected 0", ready0, ready1);
        end
        checks++;
        if ({douta0, doutb0, douta1, doutb1} !== 128'h0 || {rvalida0, rvalidb0, rvalida1, rvalidb1} !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h %h %h %h valid %b%b%b%b expected 0",
                     douta0, doutb0, douta1, doutb1, rvalida0, rvalidb0, rvalida1, rvalidb1);
        end
        // Try to write garbage during the clear; it must be ignored.
        rst_n = 1'b1;
        ena = 1'b1; wea = 4'hF; addra = 4'd4; dina = 32'hFFFF_FFFF;
        wait_clear_done("reset");
    endtask

    task automatic test_clear_contents();
        logic [31:0] d0, d1;
        logic v0, v1e, v1;
        for (int a = 0; a < 16; a++) begin
            do_read(a[0], 4'(a), d0, v0, v1e, d1, v1);
            checks++;
            if (d0 !== CLRV || v0 !== 1'b1 || d1 !== CLRV || v1 !== 1'b1) begin
                failures++;
                $display("FAIL clear_contents addr %0d: got %h/%b %h/%b expected %h/1", a, d0, v0, d1, v1, CLRV);
            end
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] d0, d1;
        logic v0, v1e, v1;
        do_write(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0);
        do_read(1'b0, 4'd3, d0, v0, v1e, d1, v1);
        checks++;
        if (d0 !== 32'hA522A544 || v0 !== 1'b1) begin
            failures++;
            $display("FAIL byte_write_lat1: got %h/%b expected a522a544/1", d0, v0);
        end
        checks++;
        if (v1e !== 1'b0) begin
            failures++;
            $display("FAIL byte_write_outreg_early: rvalid got %b expected 0", v1e);
        end
        checks++;
        if (d1 !== 32'hA522A544 || v1 !== 1'b1) begin
            failures++;
            $display("FAIL byte_write_lat2: got %h/%b expected a522a544/1", d1, v1);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d0, d1;
        logic v0, v1e, v1;
        do_write(1'b1, 4'hF, 4'd5, 32'h0000_00FF, 1'b1, 4'hF, 4'd5, 32'hFFFF_FF00);
        do_read(1'b1, 4'd5, d0, v0, v1e, d1, v1);
        checks++;
        if (d0 !== 32'h0000_00FF || d1 !== 32'h0000_00FF || v0 !== 1'b1 || v1 !== 1'b1) begin
            failures++;
            $display("FAIL collision_full: got %h %h expected 000000ff", d0, d1);
        end
        do_write(1'b1, 4'b0011, 4'd6, 32'h1111_1111, 1'b1, 4'b0110, 4'd6, 32'h2222_2222);
        do_read(1'b0, 4'd6, d0, v0, v1e, d1, v1);
        checks++;
        if (d0 !== 32'hA522_1111 || d1 !== 32'hA522_1111) begin
            failures++;
            $display("FAIL collision_lanes: got %h %h expected a5221111", d0, d1);
        end
    endtask

    task automatic test_rdw();
        logic [31:0] d0, d1;
        logic v0, v1e, v1;
        @(negedge clk);
        ena = 1'b1; wea = 4'hF; addra = 4'd7; dina = 32'hDEAD_BEEF;
        enb = 1'b1; web = 4'h0; addrb = 4'd7;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (douta0 !== CLRV || doutb0 !== CLRV || rvalida0 !== 1'b1 || rvalidb0 !== 1'b1) begin
            failures++;
            $display("FAIL rdw_read_first: got a=%h b=%h expected %h", douta0, doutb0, CLRV);
        end
        @(negedge clk);
        checks++;
        if (douta1 !== 32'hDEAD_BEEF || doutb1 !== 32'hDEAD_BEEF || rvalida1 !== 1'b1 || rvalidb1 !== 1'b1) begin
            failures++;
            $display("FAIL rdw_write_first: got a=%h b=%h expected deadbeef", douta1, doutb1);
        end
        // Cross-port the other way, partial lanes: B writes, A reads.
        @(negedge clk);
        enb = 1'b1; web = 4'b1100; addrb = 4'd8; dinb = 32'h1234_5678;
        ena = 1'b1; wea = 4'h0; addra = 4'd8;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (douta0 !== CLRV || doutb0 !== CLRV) begin
            failures++;
            $display("FAIL rdw_cross_read_first: got a=%h b=%h expected %h", douta0, doutb0, CLRV);
        end
        @(negedge clk);
        checks++;
        if (douta1 !== 32'h1234_A5A5 || doutb1 !== 32'h1234_A5A5) begin
            failures++;
            $display("FAIL rdw_cross_write_first: got a=%h b=%h expected 1234a5a5", douta1, doutb1);
        end
        do_read(1'b1, 4'd7, d0, v0, v1e, d1, v1);
        checks++;
        if (d0 !== 32'hDEAD_BEEF || d1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rdw_readback7: got %h %h expected deadbeef", d0, d1);
        end
    endtask

    task automatic test_clr_req();
        logic [31:0] d0, d1;
        logic v0, v1e, v1;
        @(negedge clk);
        clr_req = 1'b1;
        ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'h0000_0001;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin clr_req = 1'b0; addra = 4'd9; dina = 32'h0000_0055; end
            if (k == 4) clr_req = 1'b1;
            if (k == 5) clr_req = 1'b0;
            if (k == 9) begin ena = 1'b0; wea = '0; end
            checks++;
            if (ready0 !== (k == 9) || ready1 !== (k == 9)) begin
                failures++;
                $display("FAIL clr_req_ready edge %0d: got %b/%b expected %b", k, ready0, ready1, (k == 9));
            end
            if (k == 1) begin
                checks++;
                if (douta0 !== CLRV || rvalida0 !== 1'b1) begin
                    failures++;
                    $display("FAIL clr_req_last_read: got %h/%b expected %h/1", douta0, rvalida0, CLRV);
                end
            end
            if (k == 2) begin
                checks++;
                if (douta1 !== 32'h0000_0001 || rvalida1 !== 1'b1) begin
                    failures++;
                    $display("FAIL clr_req_last_write: got %h/%b expected 00000001/1", douta1, rvalida1);
                end
            end
            if (k >= 3) begin
                checks++;
                if (douta0 !== 32'h0 || rvalida0 !== 1'b0 || douta1 !== 32'h0 || rvalida1 !== 1'b0) begin
                    failures++;
                    $display("FAIL clr_req_dout_zero edge %0d: got %h/%b %h/%b expected 0",
                             k, douta0, rvalida0, douta1, rvalida1);
                end
            end
        end
        do_read(1'b0, 4'd2, d0, v0, v1e, d1, v1);
        checks++;
        if (d0 !== CLRV || d1 !== CLRV) begin
            failures++;
            $display("FAIL clr_req_addr2: got %h %h expected %h", d0, d1, CLRV);
        end
        do_read(1'b1, 4'd9, d0, v0, v1e, d1, v1);
        checks++;
        if (d0 !== CLRV || d1 !== CLRV) begin
            failures++;
            $display("FAIL clr_req_addr9: got %h %h expected %h", d0, d1, CLRV);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] d0, d1;
        logic v0, v1e, v1;
        do_write(1'b1, 4'hF, 4'd15, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0 || {douta0, doutb0, douta1, doutb1} !== 128'h0 ||
            {rvalida0, rvalidb0, rvalida1, rvalidb1} !== 4'h0) begin
            failures++;
            $display("FAIL mid_clear_reset_outputs: ready %b/%b douta %h/%h", ready0, ready1, douta0, douta1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear_done("mid_clear");
        do_read(1'b0, 4'd15, d0, v0, v1e, d1, v1);
        checks++;
        if (d0 !== CLRV || d1 !== CLRV) begin
            failures++;
            $display("FAIL mid_clear_addr15: got %h %h expected %h", d0, d1, CLRV);
        end
    endtask

    initial begin
        test_reset();
        test_clear_contents();
        test_byte_write();
        test_collision();
        test_rdw();
        test_clr_req();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
